// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// instruction encodings, FSM states, default width and divide-by-zero LO value.
package hilo_pkg;

    localparam int WIDTH_DEF = 32;

    // Divide-by-zero LO result; sized wide and truncated to WIDTH at use.
    localparam logic [63:0] DIVZ_LO = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // True for the multi-cycle instruction classes that start a sequence.
    function automatic logic op_is_muldiv(input logic [2:0] op);
        logic res;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-side request / HI-LO result bundle of the multiply/divide controller.
interface hilo_muldiv_ctrl_if #(parameter int WIDTH = 32);

    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, src_a, src_b, flush,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b, flush,
        output stall, busy, done, hi, lo
    );

endinterface

// File: rtl/hilo_muldiv_ctrl_muldiv_iter.sv
// Iterative datapath: 2*WIDTH accumulator shared by shift-add multiply
// (multiplier in the low half, product builds from the top) and restoring
// divide (remainder in the high half, quotient shifts into the low half).
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_step,
    input  logic               i_mode_div,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_trial;

    // One multiply or divide iteration computed from the current accumulator.
    always_comb begin
        w_acc_nxt = r_acc;
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shl     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_trial   = w_shl - {1'b0, r_b};
        if (i_mode_div) begin
            if (!w_trial[WIDTH]) begin
                w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Load operands on start, advance one iteration per step cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {(2*WIDTH){1'b0}};
            r_b   <= {WIDTH{1'b0}};
        end else if (i_start) begin
            r_acc <= {{WIDTH{1'b0}}, i_op_a};
            r_b   <= i_op_b;
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner beside EX: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs the
// WIDTH-cycle iteration, applies sign correction and commits HI/LO while
// holding the front of the pipeline.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    hilo_muldiv_ctrl_if.slave   bus
);

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_divz;
    logic [WIDTH-1:0]   r_src_a_raw;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_div_op;
    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Decode the EX instruction and form operand magnitudes for signed ops.
    always_comb begin
        w_signed = 1'b0;
        w_div_op = 1'b0;
        case (op_e'(bus.op))
            OP_MULT:  w_signed = 1'b1;
            OP_DIV:   begin w_signed = 1'b1; w_div_op = 1'b1; end
            OP_DIVU:  w_div_op = 1'b1;
            default:  begin w_signed = 1'b0; w_div_op = 1'b0; end
        endcase
        w_accept = bus.op_valid && op_is_muldiv(bus.op) && !bus.flush
                && (r_state == ST_IDLE);
        w_a_neg  = w_signed && bus.src_a[WIDTH-1];
        w_b_neg  = w_signed && bus.src_b[WIDTH-1];
        w_mag_a  = w_a_neg ? (~bus.src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_a;
        w_mag_b  = w_b_neg ? (~bus.src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_b;
    end

    // Next-state logic; flush returns to IDLE from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
                ST_RUN:  w_state_nxt = (r_cnt == LAST_ITER) ? ST_FIX : ST_RUN;
                ST_FIX:  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequence context latched at accept, iteration counter, busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= {CW{1'b0}};
            r_is_div    <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_divz      <= 1'b0;
            r_src_a_raw <= {WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt       <= {CW{1'b0}};
                r_is_div    <= w_div_op;
                r_neg_res   <= w_a_neg ^ w_b_neg;
                r_neg_rem   <= w_a_neg;
                r_divz      <= w_div_op && (bus.src_b == {WIDTH{1'b0}});
                r_src_a_raw <= bus.src_a;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            r_busy <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FIX);
            r_done <= (w_state_nxt == ST_FIX);
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_accept),
        .i_step     (r_state == ST_RUN),
        .i_mode_div (r_is_div),
        .i_op_a     (w_mag_a),
        .i_op_b     (w_mag_b),
        .o_acc      (w_acc)
    );

    // Sign fix-up of the raw magnitude result; divide by zero overrides.
    always_comb begin
        w_prod = r_neg_res ? (~w_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_acc;
        w_quo  = r_neg_res ? (~w_acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                           : w_acc[WIDTH-1:0];
        w_rem  = r_neg_rem ? (~w_acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                           : w_acc[2*WIDTH-1:WIDTH];
        if (r_divz) begin
            w_fix_hi = r_src_a_raw;
            w_fix_lo = WIDTH'(DIVZ_LO);
        end else if (r_is_div) begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // HI/LO architectural registers: commit leaving FIX, or MTHI/MTLO in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= {WIDTH{1'b0}};
            r_lo <= {WIDTH{1'b0}};
        end else if (bus.flush) begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end else if (r_state == ST_FIX) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if ((r_state == ST_IDLE) && bus.op_valid && (bus.op == OP_MTHI)) begin
            r_hi <= bus.src_a;
        end else if ((r_state == ST_IDLE) && bus.op_valid && (bus.op == OP_MTLO)) begin
            r_lo <= bus.src_a;
        end
    end

    assign bus.stall = w_accept || (r_state == ST_RUN);
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: the driver pushes reference HI/LO
// results at issue, the monitor pops and compares after each done pulse.
module tb_hilo_muldiv_ctrl;

    localparam int W = 32;
    localparam logic [2:0] C_NONE  = 3'b000;
    localparam logic [2:0] C_MULT  = 3'b001;
    localparam logic [2:0] C_MULTU = 3'b010;
    localparam logic [2:0] C_DIV   = 3'b011;
    localparam logic [2:0] C_DIVU  = 3'b100;
    localparam logic [2:0] C_MTHI  = 3'b101;
    localparam logic [2:0] C_MTLO  = 3'b110;
    localparam logic [2:0] C_RSVD  = 3'b111;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_seen = 0;
    int          done_exp  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        pend = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference result {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'd0;
        case (op)
            C_MULT:  res = 64'(sa * sb);
            C_MULTU: res = {32'd0, a} * {32'd0, b};
            C_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            C_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply/divide and follow it to completion.
    task automatic run_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int n;
        bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.flush = 1'b0;
        #1;
        check("accept_stall", 64'(bus.stall), 64'd1);
        e = ref_result(op, a, b);
        exp_q.push_back(e);
        done_exp++;
        n = 1;
        tick();
        while (bus.stall && n < 100) begin
            bus.op_valid = 1'($urandom_range(0, 1));
            bus.op       = 3'($urandom_range(0, 7));
            bus.src_a    = $urandom;
            bus.src_b    = $urandom;
            n++;
            tick();
        end
        bus.op_valid = 1'b0; bus.op = C_NONE;
        check("stall_len", 64'(n), 64'(W + 1));
        check("fix_busy", 64'(bus.busy), 64'd1);
        m_hi = e[63:32];
        m_lo = e[31:0];
        tick();
    endtask

    // MTHI / MTLO: no stall, value visible after one edge.
    task automatic run_mt(input logic [2:0] op, input logic [31:0] v);
        bus.op_valid = 1'b1; bus.op = op; bus.src_a = v; bus.flush = 1'b0;
        #1;
        check("mt_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.op_valid = 1'b0; bus.op = C_NONE;
        if (op == C_MTHI) m_hi = v; else m_lo = v;
        check("mt_hi", 64'(bus.hi), 64'(m_hi));
        check("mt_lo", 64'(bus.lo), 64'(m_lo));
    endtask

    // Monitor: on each done, compare HI/LO one cycle later against the queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (pend) begin
            if (exp_q.size() == 0) begin
                check("sb_nonempty", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_hi", 64'(bus.hi), 64'(e[63:32]));
                check("sb_lo", 64'(bus.lo), 64'(e[31:0]));
            end
        end
        if (bus.done) begin
            done_seen <= done_seen + 1;
            check("done_one_cycle", 64'(pend), 64'd0);
            check("done_busy", 64'(bus.busy), 64'd1);
        end
        pend <= bus.done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.op_valid = 1'b0; bus.op = C_NONE; bus.src_a = 32'd0; bus.src_b = 32'd0;
        bus.flush = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_busy",  64'(bus.busy),  64'd0);
        check("rst_done",  64'(bus.done),  64'd0);
        check("rst_hi",    64'(bus.hi),    64'd0);
        check("rst_lo",    64'(bus.lo),    64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Directed arithmetic cases.
        run_muldiv(C_MULT,  32'hFFFF_FFFD, 32'd7);
        run_muldiv(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_muldiv(C_DIV,   32'hFFFF_FFF9, 32'd2);
        run_muldiv(C_DIVU,  32'd10,        32'd0);
        run_muldiv(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_muldiv(C_DIV,   32'd100,       32'hFFFF_FFF9);
        run_muldiv(C_DIV,   32'hFFFF_FF00, 32'd0);

        // MTHI then MTLO back to back, then MTHI killed by flush.
        run_mt(C_MTHI, 32'h0000_1234);
        run_mt(C_MTLO, 32'h0000_5678);
        bus.op_valid = 1'b1; bus.op = C_MTHI; bus.src_a = 32'hDEAD_BEEF; bus.flush = 1'b1;
        tick();
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        check("mthi_flush_hi", 64'(bus.hi), 64'(m_hi));

        // Reserved / none opcodes do nothing.
        bus.op_valid = 1'b1; bus.op = C_RSVD; bus.src_a = 32'hAAAA_5555;
        #1;
        check("rsvd_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.op_valid = 1'b0;
        check("rsvd_busy", 64'(bus.busy), 64'd0);
        check("rsvd_hi", 64'(bus.hi), 64'(m_hi));

        // Flush in the accept cycle prevents the start.
        bus.op_valid = 1'b1; bus.op = C_MULT; bus.src_a = 32'd5; bus.src_b = 32'd6; bus.flush = 1'b1;
        #1;
        check("acc_flush_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.op_valid = 1'b0; bus.flush = 1'b0;
        check("acc_flush_busy", 64'(bus.busy), 64'd0);

        // DIV flushed in RUN cycle 10.
        bus.op_valid = 1'b1; bus.op = C_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd7;
        #1;
        check("fl_accept_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.op_valid = 1'b0;
        repeat (10) tick();
        check("fl_run_busy", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fl_stall", 64'(bus.stall), 64'd0);
        check("fl_busy",  64'(bus.busy),  64'd0);
        repeat (40) tick();
        check("fl_hi", 64'(bus.hi), 64'(m_hi));
        check("fl_lo", 64'(bus.lo), 64'(m_lo));

        // Reset asserted in RUN cycle 5.
        bus.op_valid = 1'b1; bus.op = C_MULT; bus.src_a = 32'd123; bus.src_b = 32'd456;
        tick();
        bus.op_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        check("ar_stall", 64'(bus.stall), 64'd0);
        check("ar_busy",  64'(bus.busy),  64'd0);
        check("ar_hi",    64'(bus.hi),    64'd0);
        check("ar_lo",    64'(bus.lo),    64'd0);
        #3 rst_n = 1'b1;
        tick();

        // Randomized mix.
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = $urandom_range(0, 5);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            case (kind)
                0: op = C_MULT;
                1: op = C_MULTU;
                2: op = C_DIV;
                3: op = C_DIVU;
                4: op = C_MTHI;
                default: op = C_MTLO;
            endcase
            if (kind < 4) run_muldiv(op, a, b);
            else run_mt(op, a);
        end

        repeat (3) tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_seen), 64'(done_exp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
